// File: rtl/store_buf.sv
// ---------------------------------------------------------------------------
// store_buf : posted-write buffer between the MEM stage and a slow data memory
//
// MEM-stage stores are retired into a DEPTH-entry circular FIFO in a single
// cycle. A two-state drain FSM presents the head entry to memory through a
// req/ack handshake. Loads in MEM see buffered data through a combinational
// youngest-match bypass. A store whose word address matches the youngest
// entry is coalesced into that entry instead of taking a new slot.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-low reset
//   wr_en     in   MEM-stage store valid
//   wr_addr   in   store byte address (word compare on [AW-1:2])
//   wr_data   in   store data
//   full      out  no free entry (store stall to the hazard unit)
//   empty     out  no entries
//   count     out  occupancy, 0..DEPTH
//   ld_addr   in   MEM-stage load address
//   ld_hit    out  some buffered entry matches the ld_addr word
//   ld_data   out  data of the youngest matching entry, 0 when no hit
//   mem_req   out  drain request to data memory
//   mem_addr  out  head entry address
//   mem_wdata out  head entry data
//   mem_ack   in   memory accepted the head entry this cycle
//   ovf       out  sticky flag: a store was dropped while full
// ---------------------------------------------------------------------------
module store_buf #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [DW-1:0]            wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  input  logic [AW-1:0]            ld_addr,
  output logic                     ld_hit,
  output logic [DW-1:0]            ld_data,
  output logic                     mem_req,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_wdata,
  input  logic                     mem_ack,
  output logic                     ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Storage and bookkeeping registers
  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  state_e           state_q, state_d;
  logic             ovf_q, ovf_d;

  // Push/pop decode
  logic [PW-1:0]    youngIdx;
  logic             doCoalesce;
  logic             doPush;
  logic             doDrop;
  logic             doPop;

  // Bypass scan index
  logic [PW-1:0]    scanIdx;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign ovf       = ovf_q;
  assign mem_req   = (state_q == BUSY);
  assign mem_addr  = addr_q[head_q];
  assign mem_wdata = data_q[head_q];

  // Coalescing requires at least two entries so the youngest entry can never
  // be the head that is currently being presented to memory. full is the
  // registered flag, so an ack in the same cycle does not make room for a push.
  assign youngIdx   = tail_q - PW'(1);
  assign doCoalesce = wr_en && (count_q >= CW'(2)) &&
                      (addr_q[youngIdx][AW-1:2] == wr_addr[AW-1:2]);
  assign doPush     = wr_en && !doCoalesce && !full;
  assign doDrop     = wr_en && !doCoalesce && full;
  assign doPop      = (state_q == BUSY) && mem_ack;

  // Next-state for pointers, occupancy, valid bits and the sticky overflow flag
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    if (doPop) begin
      head_d           = head_q + PW'(1);
      valid_d[head_q]  = 1'b0;
    end
    if (doPush) begin
      tail_d           = tail_q + PW'(1);
      valid_d[tail_q]  = 1'b1;
    end
    if (doPush && !doPop) begin
      count_d = count_q + CW'(1);
    end else if (doPop && !doPush) begin
      count_d = count_q - CW'(1);
    end
    if (doDrop) begin
      ovf_d = 1'b1;
    end
  end

  // Drain FSM: BUSY exactly while the buffer holds entries after this edge,
  // which gives a one-cycle push-to-request latency and keeps the head stable
  // until it is acknowledged.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (count_d != '0) state_d = BUSY;
      BUSY: if (count_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and bookkeeping registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  // Entry array: a new store lands at the tail, a coalesced store overwrites
  // only the data of the youngest entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (doPush) begin
        addr_q[tail_q] <= wr_addr;
        data_q[tail_q] <= wr_data;
      end
      if (doCoalesce) begin
        data_q[youngIdx] <= wr_data;
      end
    end
  end

  // Load bypass: scan from the head (oldest) towards the tail so that the
  // last match found is the youngest one. The in-flight head is included.
  always_comb begin
    ld_hit  = 1'b0;
    ld_data = '0;
    scanIdx = head_q;
    for (int k = 0; k < DEPTH; k++) begin
      scanIdx = head_q + PW'(k);
      if (valid_q[scanIdx] && (addr_q[scanIdx][AW-1:2] == ld_addr[AW-1:2])) begin
        ld_hit  = 1'b1;
        ld_data = data_q[scanIdx];
      end
    end
  end

endmodule

// File: tb/tb_store_buf.sv
// ---------------------------------------------------------------------------
// tb_store_buf : directed self-checking bench for store_buf (DEPTH=4).
// ---------------------------------------------------------------------------
module tb_store_buf;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   wr_en;
  logic [AW-1:0]          wr_addr;
  logic [DW-1:0]          wr_data;
  logic                   full;
  logic                   empty;
  logic [$clog2(DEPTH):0] count;
  logic [AW-1:0]          ld_addr;
  logic                   ld_hit;
  logic [DW-1:0]          ld_data;
  logic                   mem_req;
  logic [AW-1:0]          mem_addr;
  logic [DW-1:0]          mem_wdata;
  logic                   mem_ack;
  logic                   ovf;

  int testsRun    = 0;
  int testsFailed = 0;

  store_buf #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .ld_addr   (ld_addr),
    .ld_hit    (ld_hit),
    .ld_data   (ld_data),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, return 1 time unit after the edge
  task automatic applyStimulus(input logic we, input logic [31:0] wa,
                               input logic [31:0] wd, input logic ack);
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    mem_ack = ack;
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    mem_ack = 1'b0;
  endtask

  // Check the presented head entry, then acknowledge it (optional idle gap)
  task automatic drainCheck(input string tag, input logic [31:0] expAddr,
                            input logic [31:0] expData, input bit gap);
    checkOutput({tag, " mem_req"},   mem_req,   1'b1);
    checkOutput({tag, " mem_addr"},  mem_addr,  expAddr);
    checkOutput({tag, " mem_wdata"}, mem_wdata, expData);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
    if (gap) applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    reset   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    ld_addr = '0;
    mem_ack = 1'b0;
    #1;
    checkOutput("reset empty",   empty,   1'b1);
    checkOutput("reset full",    full,    1'b0);
    checkOutput("reset count",   count,   3'd0);
    checkOutput("reset mem_req", mem_req, 1'b0);
    checkOutput("reset ovf",     ovf,     1'b0);
    checkOutput("reset ld_hit",  ld_hit,  1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Three stores, no ack: head must be held steady
    applyStimulus(1'b1, 32'h10, 32'hA, 1'b0);
    checkOutput("t1 req after first push", mem_req, 1'b1);
    checkOutput("t1 count 1", count, 3'd1);
    applyStimulus(1'b1, 32'h14, 32'hB, 1'b0);
    checkOutput("t1 head addr after 2", mem_addr, 32'h10);
    applyStimulus(1'b1, 32'h18, 32'hC, 1'b0);
    checkOutput("t1 count 3", count, 3'd3);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
    checkOutput("t1 held addr",  mem_addr,  32'h10);
    checkOutput("t1 held wdata", mem_wdata, 32'hA);

    // Drain with spaced ack pulses
    drainCheck("t2 d0", 32'h10, 32'hA, 1'b1);
    drainCheck("t2 d1", 32'h14, 32'hB, 1'b1);
    drainCheck("t2 d2", 32'h18, 32'hC, 1'b0);
    checkOutput("t2 empty",   empty,   1'b1);
    checkOutput("t2 mem_req", mem_req, 1'b0);
    checkOutput("t2 count",   count,   3'd0);

    // Fill, drop on full, coalesce on full, push-while-full with ack
    applyStimulus(1'b1, 32'h100, 32'h1, 1'b0);
    applyStimulus(1'b1, 32'h104, 32'h2, 1'b0);
    applyStimulus(1'b1, 32'h108, 32'h3, 1'b0);
    applyStimulus(1'b1, 32'h10C, 32'h4, 1'b0);
    checkOutput("t3 full",  full,  1'b1);
    checkOutput("t3 count", count, 3'd4);
    applyStimulus(1'b1, 32'h40, 32'h55, 1'b0);
    checkOutput("t3 drop count", count, 3'd4);
    checkOutput("t3 drop ovf",   ovf,   1'b1);
    applyStimulus(1'b1, 32'h10C, 32'hFF, 1'b0);
    checkOutput("t3 coalesce count", count, 3'd4);
    ld_addr = 32'h10C;
    #1;
    checkOutput("t3 ld hit coalesced",  ld_hit,  1'b1);
    checkOutput("t3 ld data coalesced", ld_data, 32'hFF);
    ld_addr = 32'h40;
    #1;
    checkOutput("t3 ld dropped miss", ld_hit, 1'b0);
    applyStimulus(1'b1, 32'h50, 32'h66, 1'b1);
    checkOutput("t3 full+ack count", count, 3'd3);
    checkOutput("t3 full+ack full",  full,  1'b0);
    ld_addr = 32'h50;
    #1;
    checkOutput("t3 full+ack not stored", ld_hit, 1'b0);
    drainCheck("t3 d0", 32'h104, 32'h2,  1'b0);
    drainCheck("t3 d1", 32'h108, 32'h3,  1'b0);
    drainCheck("t3 d2", 32'h10C, 32'hFF, 1'b0);
    checkOutput("t3 empty", empty, 1'b1);
    checkOutput("t3 ovf sticky", ovf, 1'b1);

    // Bypass picks the youngest of several matches
    applyStimulus(1'b1, 32'h20, 32'h1, 1'b0);
    applyStimulus(1'b1, 32'h24, 32'h2, 1'b0);
    applyStimulus(1'b1, 32'h20, 32'h3, 1'b0);
    checkOutput("t4 count no coalesce", count, 3'd3);
    ld_addr = 32'h23;
    #1;
    checkOutput("t4 ld hit 0x23",  ld_hit,  1'b1);
    checkOutput("t4 ld data 0x23", ld_data, 32'h3);
    ld_addr = 32'h24;
    #1;
    checkOutput("t4 ld data 0x24", ld_data, 32'h2);
    ld_addr = 32'h30;
    #1;
    checkOutput("t4 ld miss hit",  ld_hit,  1'b0);
    checkOutput("t4 ld miss data", ld_data, 32'h0);
    drainCheck("t4 d0", 32'h20, 32'h1, 1'b0);
    drainCheck("t4 d1", 32'h24, 32'h2, 1'b0);
    drainCheck("t4 d2", 32'h20, 32'h3, 1'b0);
    checkOutput("t4 empty", empty, 1'b1);

    // Simultaneous push and ack at count=2 across pointer wrap
    applyStimulus(1'b1, 32'h200, 32'h1000, 1'b0);
    applyStimulus(1'b1, 32'h204, 32'h1001, 1'b0);
    checkOutput("t5 count start", count, 3'd2);
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("t5 head addr %0d", i),  mem_addr,  32'h200 + 32'(4 * i));
      checkOutput($sformatf("t5 head data %0d", i),  mem_wdata, 32'h1000 + 32'(i));
      applyStimulus(1'b1, 32'h208 + 32'(4 * i), 32'h1002 + 32'(i), 1'b1);
      checkOutput($sformatf("t5 count %0d", i), count, 3'd2);
    end
    drainCheck("t5 d0", 32'h228, 32'h100A, 1'b0);
    drainCheck("t5 d1", 32'h22C, 32'h100B, 1'b0);
    checkOutput("t5 empty", empty, 1'b1);

    // Reset in the middle of a drain
    applyStimulus(1'b1, 32'h300, 32'h7, 1'b0);
    applyStimulus(1'b1, 32'h304, 32'h8, 1'b0);
    applyStimulus(1'b1, 32'h308, 32'h9, 1'b0);
    checkOutput("t6 count 3", count, 3'd3);
    checkOutput("t6 req busy", mem_req, 1'b1);
    #3;
    reset   = 1'b0;
    ld_addr = 32'h300;
    #1;
    checkOutput("t6 async mem_req", mem_req, 1'b0);
    checkOutput("t6 async count",   count,   3'd0);
    checkOutput("t6 async empty",   empty,   1'b1);
    checkOutput("t6 async ovf",     ovf,     1'b0);
    checkOutput("t6 async ld_hit",  ld_hit,  1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
      checkOutput($sformatf("t6 idle ack count %0d", i), count,   3'd0);
      checkOutput($sformatf("t6 idle ack req %0d", i),   mem_req, 1'b0);
    end
    applyStimulus(1'b1, 32'h400, 32'h77, 1'b0);
    checkOutput("t6 post count", count,    3'd1);
    checkOutput("t6 post addr",  mem_addr, 32'h400);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/store_buf.md
Name: store_buf

Overview:
- Posted-write buffer between the MEM stage and a slow data memory.
- MEM-stage stores are retired into a circular FIFO in one cycle. Entries drain to memory through a req/ack handshake.
- Loads in MEM see buffered data through a youngest-match bypass.
- `full` feeds the hazard unit as a store stall.

Parameters:
- DEPTH, 4, number of entries (power of 2, ≥2)
- AW, 32, address width (byte address; compare uses [AW-1:2])
- DW, 32, data width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- wr_en  in  1  MEM-stage store valid (MemWriteM)
- wr_addr  in  AW  store byte address (Alu_outM)
- wr_data  in  DW  store data (busbM)
- full  out  1  no free entry; hazard unit stalls F/D/E/M while set
- empty  out  1  no entries
- count  out  $clog2(DEPTH)+1  occupancy
- ld_addr  in  AW  MEM-stage load address
- ld_hit  out  1  buffered entry matches ld_addr word
- ld_data  out  DW  data of youngest matching entry
- mem_req  out  1  drain request to data memory
- mem_addr  out  AW  head entry address
- mem_wdata  out  DW  head entry data
- mem_ack  in  1  memory accepted head entry this cycle
- ovf  out  1  sticky: store dropped while full

Behaviour:
- Reset (reset==0, async) forces:
  - head, tail and count to 0;
  - all valid bits clear;
  - empty=1, full=0, mem_req=0, ovf=0, ld_hit=0.
- Reset mid-drain discards all entries; mem_req drops immediately.
- Storage: DEPTH-entry array {addr, data}. head/tail pointers wrap modulo DEPTH. full = (count==DEPTH), empty = (count==0), both from registered count.
- Drain FSM, 2 states:
  - IDLE: mem_req=0. → BUSY when count≠0 at clock edge.
  - BUSY: mem_req=1; mem_addr/mem_wdata = head entry, held stable until mem_ack.
  - On mem_ack in BUSY: pop head, head+1. Stay BUSY if count after pop ≠0, else → IDLE.
  - mem_ack in IDLE is ignored.
  - Min latency push→mem_req = 1 cycle.
- Push rules, evaluated at clock edge when wr_en=1:
  - Coalesce: if count≥2 and wr_addr[AW-1:2] equals the youngest entry's word address, overwrite that entry's data; count unchanged. Accepted even when full. The youngest entry is never the in-flight head when count≥2.
  - Else if !full: write at tail, tail+1, count+1.
  - Else (full, no coalesce): store dropped, ovf←1 (sticky until reset).
- Simultaneous push and ack: both take effect; count unchanged net. Push while full is not accepted even if ack in same cycle, because full is registered.
- Count range 0..DEPTH; never exceeds DEPTH, never underflows.
- Load bypass (combinational):
  - Compare ld_addr[AW-1:2] against all valid entries, including the in-flight head.
  - ld_hit=1 if any match; ld_data = youngest match (nearest to tail).
  - ld_data=0 when no hit.
  - Same-cycle wr_en is not visible to the bypass; the hazard unit forwards it.
- Full word stores only; no byte enables.

Test Plan:
- Reset, then 3 stores (0x10←0xA, 0x14←0xB, 0x18←0xC) with mem_ack tied 0 → count=3, mem_req=1, mem_addr=0x10, mem_wdata=0xA held steady.
- Continue from the previous case: pulse mem_ack 3 times, 1 cycle apart → drain order 0x10/0xA, 0x14/0xB, 0x18/0xC; empty=1, mem_req=0 after last ack.
- Fill 4 distinct stores with mem_ack=0 → full=1. 5th store to new addr 0x40 → dropped, ovf=1, count=4. 6th store to youngest addr with data 0xFF → coalesced; later drain emits 0xFF for that addr.
- Stores 0x20←1, 0x24←2, 0x20←3 (not youngest, no coalesce), ld_addr=0x23 → ld_hit=1, ld_data=3. ld_addr=0x30 → ld_hit=0, ld_data=0.
- count=2, push with mem_ack in same cycle → count stays 2, tail and head both advance. Pointer wrap exercised over 10 such cycles without data corruption.
- Assert reset mid-BUSY with count=3 → mem_req=0 and count=0 immediately without clock. After release, mem_ack pulses are ignored.
